// File: rtl/slice_rmw_unit_if.sv
// Command/response handshake bundle for slice_rmw_unit.
// The master issues commands and accepts responses; the slave executes them.
interface slice_rmw_unit_if #(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int LW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_lsb;
  logic [LW:0]   cmd_width;
  logic [DW-1:0] cmd_data;
  logic          cmd_ret_old;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_lsb, cmd_width, cmd_data, cmd_ret_old,
    output resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_lsb, cmd_width, cmd_data, cmd_ret_old,
    input  resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/slice_rmw_unit.sv
// Read-modify-write engine applying compound/increment assignments to a bit
// slice of a register-file entry, one operation in flight at a time.
module slice_rmw_unit #(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int LW = 5
) (
  input  logic                clk,
  input  logic                rst,
  slice_rmw_unit_if.slave     bus,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data
);

  localparam int WW = LW + 2;
  localparam int NE = 1 << AW;

  localparam logic [3:0] OP_ASSIGN = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_SHL    = 4'd7;
  localparam logic [3:0] OP_SHR    = 4'd8;
  localparam logic [3:0] OP_ASHL   = 4'd9;
  localparam logic [3:0] OP_ASHR   = 4'd10;
  localparam logic [3:0] OP_INC    = 4'd11;
  localparam logic [3:0] OP_DEC    = 4'd12;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] lsb_q, lsb_d;
  logic [LW:0]   width_q, width_d;
  logic [DW-1:0] data_q, data_d;
  logic          ret_old_q, ret_old_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] mem_q [NE];
  logic [DW-1:0] entry_d;

  logic          latch_en, exec_en, wr_en;
  logic [WW-1:0] slice_w, span, shamt;
  logic          err, over, sign;
  logic [DW-1:0] mask, entry, old_val, opnd, result, new_val;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = (state_q == ST_IDLE) && !rst;
    bus.resp_valid = (state_q == ST_RESP);
    latch_en       = bus.cmd_valid && bus.cmd_ready;
    exec_en        = (state_q == ST_EXEC);
    wr_en          = exec_en && !err;
  end

  // Slice geometry: width 0 means a full-entry slice; the mask marks the W low bits.
  always_comb begin
    slice_w = (width_q == '0) ? WW'(DW) : {1'b0, width_q};
    span    = {2'b00, lsb_q} + slice_w;
    err     = (op_q > OP_DEC) || ({1'b0, width_q} > WW'(DW)) || (span > WW'(DW));
    mask    = (slice_w >= WW'(DW)) ? '1 : ~({DW{1'b1}} << slice_w);
    entry   = mem_q[addr_q];
    old_val = (entry >> lsb_q) & mask;
    opnd    = data_q & mask;
    shamt   = {1'b0, data_q[LW:0]};
    over    = (shamt >= slice_w);
    sign    = |(old_val & mask & ~(mask >> 1));
  end

  // All results are reduced modulo 2**W by the final mask.
  always_comb begin
    result = '0;
    case (op_q)
      OP_ASSIGN: result = opnd;
      OP_ADD:    result = old_val + opnd;
      OP_SUB:    result = old_val - opnd;
      OP_MUL:    result = old_val * opnd;
      OP_AND:    result = old_val & opnd;
      OP_OR:     result = old_val | opnd;
      OP_XOR:    result = old_val ^ opnd;
      OP_SHL,
      OP_ASHL:   result = over ? '0 : (old_val << shamt);
      OP_SHR:    result = over ? '0 : (old_val >> shamt);
      OP_ASHR: begin
        if (over) result = sign ? mask : '0;
        else      result = (old_val >> shamt) | (sign ? (mask & ~(mask >> shamt)) : '0);
      end
      OP_INC:    result = old_val + 1'b1;
      OP_DEC:    result = old_val - 1'b1;
      default:   result = '0;
    endcase
    new_val = result & mask;
    entry_d = (entry & ~(mask << lsb_q)) | (new_val << lsb_q);
  end

  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    lsb_d       = lsb_q;
    width_d     = width_q;
    data_d      = data_q;
    ret_old_d   = ret_old_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    if (latch_en) begin
      op_d      = bus.cmd_op;
      addr_d    = bus.cmd_addr;
      lsb_d     = bus.cmd_lsb;
      width_d   = bus.cmd_width;
      data_d    = bus.cmd_data;
      ret_old_d = bus.cmd_ret_old;
    end
    if (exec_en) begin
      resp_err_d  = err;
      resp_data_d = err ? '0 : (ret_old_q ? old_val : new_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      addr_q      <= '0;
      lsb_q       <= '0;
      width_q     <= '0;
      data_q      <= '0;
      ret_old_q   <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      lsb_q       <= lsb_d;
      width_q     <= width_d;
      data_q      <= data_d;
      ret_old_q   <= ret_old_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Reset clears the whole file, which also cancels a write due in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_q] <= entry_d;
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
  assign rd_data       = mem_q[rd_addr];

endmodule

// File: tb/tb_slice_rmw_unit.sv
// Scoreboard bench for slice_rmw_unit: directed commands push expected
// responses; a negedge monitor pops and compares each accepted response.
module tb_slice_rmw_unit;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  int          n_checks;
  int          n_fail;
  exp_t        sb_q [$];

  slice_rmw_unit_if #(.DW(32), .AW(4), .LW(5)) bus ();

  slice_rmw_unit #(.DW(32), .AW(4), .LW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkEntry(input string name, input logic [3:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] addr, input logic [4:0] lsb,
                               input logic [5:0] width, input logic [31:0] data, input logic ret_old,
                               input logic [31:0] exp_data, input logic exp_err, input logic expect_resp);
    bit ok;
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    if (expect_resp) sb_q.push_back(e);
    bus.cmd_op      = op;
    bus.cmd_addr    = addr;
    bus.cmd_lsb     = lsb;
    bus.cmd_width   = width;
    bus.cmd_data    = data;
    bus.cmd_ret_old = ret_old;
    bus.cmd_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL cmd_handshake_timeout: got cmd_ready=0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL resp_timeout: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_resp: got data 0x%08h, expected no response", bus.resp_data);
      end else begin
        e = sb_q.pop_front();
        checkOutput("resp_data", bus.resp_data, e.data);
        checkOutput("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    rd_addr = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_lsb = '0;
    bus.cmd_width = '0;
    bus.cmd_data = '0;
    bus.cmd_ret_old = 1'b0;
    bus.resp_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    checkOutput("cmd_ready_in_reset", {31'b0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    checkOutput("reset_resp_data", bus.resp_data, 32'd0);
    checkOutput("reset_resp_err", {31'b0, bus.resp_err}, 32'd0);
    checkEntry("reset_entry5", 4'd5, 32'd0);
    @(posedge clk);
    #1;

    // ADD overflow within a 4-bit slice.
    applyStimulus(4'd0, 4'd0, 5'd0, 6'd0, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd1, 4'd0, 5'd4, 6'd4, 32'h3, 1'b0, 32'h2, 1'b0, 1'b1);
    waitDrain();
    checkEntry("add_entry0", 4'd0, 32'h0000_0020);

    // Postfix versus prefix increment, then full-width wrap.
    applyStimulus(4'd0, 4'd1, 5'd0, 6'd0, 32'd7, 1'b0, 32'd7, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd11, 4'd1, 5'd0, 6'd0, 32'h0, 1'b1, 32'd7, 1'b0, 1'b1);
    waitDrain();
    checkEntry("inc_post_entry1", 4'd1, 32'd8);
    applyStimulus(4'd11, 4'd1, 5'd0, 6'd0, 32'h0, 1'b0, 32'd9, 1'b0, 1'b1);
    waitDrain();
    checkEntry("inc_pre_entry1", 4'd1, 32'd9);
    applyStimulus(4'd0, 4'd1, 5'd0, 6'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd11, 4'd1, 5'd0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitDrain();
    checkEntry("inc_wrap_entry1", 4'd1, 32'h0);
    applyStimulus(4'd12, 4'd1, 5'd0, 6'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    waitDrain();
    checkEntry("dec_wrap_entry1", 4'd1, 32'hFFFF_FFFF);

    // Arithmetic and over-range shifts on a 4-bit slice at bit 8.
    applyStimulus(4'd0, 4'd2, 5'd0, 6'd0, 32'h0000_0F00, 1'b0, 32'h0000_0F00, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd10, 4'd2, 5'd8, 6'd4, 32'd1, 1'b0, 32'hF, 1'b0, 1'b1);
    waitDrain();
    checkEntry("ashr_entry2", 4'd2, 32'h0000_0F00);
    applyStimulus(4'd10, 4'd2, 5'd8, 6'd4, 32'd40, 1'b0, 32'hF, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(4'd8, 4'd2, 5'd8, 6'd4, 32'd40, 1'b0, 32'h0, 1'b0, 1'b1);
    waitDrain();
    checkEntry("shr_over_entry2", 4'd2, 32'h0);

    // Error cases leave the entry untouched.
    applyStimulus(4'd1, 4'd0, 5'd30, 6'd4, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
    waitDrain();
    checkEntry("err_range_entry0", 4'd0, 32'h0000_0020);
    applyStimulus(4'd14, 4'd0, 5'd0, 6'd4, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(4'd0, 4'd0, 5'd0, 6'd33, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
    waitDrain();
    checkEntry("err_width_entry0", 4'd0, 32'h0000_0020);

    // MUL truncation with postfix return; SUB and SHL inside an upper byte.
    applyStimulus(4'd3, 4'd0, 5'd0, 6'd8, 32'h13, 1'b1, 32'h20, 1'b0, 1'b1);
    waitDrain();
    checkEntry("mul_entry0", 4'd0, 32'h0000_0060);
    applyStimulus(4'd2, 4'd3, 5'd16, 6'd8, 32'h1, 1'b0, 32'hFF, 1'b0, 1'b1);
    waitDrain();
    checkEntry("sub_entry3", 4'd3, 32'h00FF_0000);
    applyStimulus(4'd7, 4'd3, 5'd16, 6'd8, 32'h4, 1'b0, 32'hF0, 1'b0, 1'b1);
    waitDrain();
    checkEntry("shl_entry3", 4'd3, 32'h00F0_0000);

    // Backpressure: response must hold steady while resp_ready is low.
    bus.resp_ready = 1'b0;
    applyStimulus(4'd0, 4'd4, 5'd0, 6'd16, 32'h1234_ABCD, 1'b0, 32'h0000_ABCD, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      checkOutput("bp_resp_data", bus.resp_data, 32'h0000_ABCD);
      checkOutput("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    waitDrain();
    checkEntry("bp_entry4", 4'd4, 32'h0000_ABCD);

    // Reset during EXEC drops the command and its response.
    applyStimulus(4'd0, 4'd3, 5'd0, 6'd0, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_exec_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("post_rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);
    end
    checkEntry("post_rst_entry3", 4'd3, 32'h0);
    checkEntry("post_rst_entry0", 4'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_rmw_unit.md
# slice_rmw_unit

Read-modify-write engine that applies SystemVerilog-style compound and increment/decrement assignments to a bit slice of an entry in an internal register file. It sits downstream of the lvalue-lowering stage, which resolves an assignment target to an entry, a bit offset and a width. This block executes the update and returns either the old or the new slice value. One operation is in flight at a time, with valid/ready handshakes on the command and response sides.

## Interface
- DW, 32, data width of each register-file entry.
- AW, 4, address width; the register file holds 2**AW entries.
- LW, 5, slice offset width; must equal clog2(DW).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  operation code; see Operation.
- cmd_addr  in  AW  register-file entry.
- cmd_lsb  in  LW  slice low bit.
- cmd_width  in  LW+1  slice width; 0 encodes DW.
- cmd_data  in  DW  operand; bits [LW:0] are the shift amount for shift ops.
- cmd_ret_old  in  1  1 returns the pre-update slice (postfix form); 0 returns the post-update slice.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_data  out  DW  returned slice value, zero-extended.
- resp_err  out  1  command rejected; no write performed.
- rd_addr  in  AW  debug read address.
- rd_data  out  DW  combinational debug read of the entry at rd_addr.

## Operation
- Op codes:
  - 0 ASSIGN, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR
  - 7 SHL, 8 SHR, 9 ASHL, 10 ASHR, 11 INC, 12 DEC
  - 13–15 illegal.
- Slice:
  - W = (cmd_width==0) ? DW : cmd_width.
  - old = entry[lsb +: W], zero-extended.
- Arithmetic and logic:
  - Computed modulo 2**W on old and cmd_data[W-1:0].
  - MUL keeps the low W bits only.
  - INC/DEC ignore cmd_data and wrap: all-ones+1 → 0, 0−1 → all-ones.
- Shifts:
  - Shift amount s = cmd_data[LW:0].
  - If s ≥ W: SHL/SHR/ASHL yield 0, and ASHR yields W copies of old[W-1].
  - ASHL is identical to SHL.
  - ASHR treats old[W-1] as the sign bit.
- Write-back: new value is merged into entry[lsb +: W]. Bits outside the slice are unchanged.
- resp_data = cmd_ret_old ? old : new, zero-extended to DW.
- Errors, each giving resp_err=1, resp_data=0 and no write:
  - lsb + W > DW;
  - cmd_width > DW;
  - illegal op.
- FSM:
  - IDLE: cmd_ready=1. On handshake, latch all cmd fields and go to EXEC.
  - EXEC: read the entry, compute, write the entry at the end of this cycle, register the response, go to RESP.
  - RESP: resp_valid=1. On resp_ready go to IDLE.
- cmd_ready is 0 outside IDLE; commands offered in EXEC/RESP stall.

## Timing
- Handshake at edge T. EXEC is cycle T+1. The write is visible on rd_data from T+2. resp_valid rises at T+2.
- Minimum command spacing is 3 cycles when resp_ready is held at 1.
- resp_data and resp_err stay stable while resp_valid=1 && !resp_ready.
- A command offered together with resp_ready in RESP is not accepted until the following IDLE cycle.
- Reset values: state IDLE, all entries 0, resp_valid=0, resp_data=0, resp_err=0.
- cmd_ready=0 during any cycle in which rst=1.
- Reset in the EXEC cycle suppresses the write; reset dominates. Reset in RESP drops the pending response.
- rd_data is combinational from the array, including during reset cycles; it shows pre-reset contents until the reset edge.

## Test plan
- ADD overflow: entry0=0x0000_00F0; ADD lsb=4 width=4 data=0x3, ret_old=0 → resp_data=0x2, entry0=0x0000_0020.
- Postfix vs prefix increment:
  - entry1=7; INC width=0 ret_old=1 → resp 7, entry1=8.
  - INC ret_old=0 → resp 9, entry1=9.
  - entry1=0xFFFF_FFFF; INC → entry1=0.
- Arithmetic shift: entry2=0x0000_0F00; ASHR lsb=8 width=4 data=1 → slice 0xF, entry unchanged 0x0F00.
- Over-range shift: ASHR with data=40 → 0xF; SHR with data=40 → slice 0, entry2=0x0000_0000.
- Error: lsb=30 width=4 → resp_err=1, resp_data=0, entry untouched. Op 14 → resp_err=1.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles: resp stable, cmd_ready=0.
  - Assert rst in the EXEC cycle of an ASSIGN data=0x55 to entry3: entry3=0, resp_valid stays 0, cmd_ready=1 the cycle after rst deasserts.
